// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, mode tables and helpers
// for the video timing generator.
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_cfg_t;

  localparam bit POL_POS = 1'b1;
  localparam bit POL_NEG = 1'b0;

  localparam axis_cfg_t H_1080P60 = '{1920, 88, 44, 148};
  localparam axis_cfg_t V_1080P60 = '{1080, 4, 5, 36};
  localparam bit        P_1080P60 = POL_POS;

  localparam axis_cfg_t H_720P60  = '{1280, 110, 40, 220};
  localparam axis_cfg_t V_720P60  = '{720, 5, 5, 20};
  localparam bit        P_720P60  = POL_POS;

  localparam axis_cfg_t H_480P60  = '{640, 16, 96, 48};
  localparam axis_cfg_t V_480P60  = '{480, 10, 2, 33};
  localparam bit        P_480P60  = POL_NEG;

  function automatic int unsigned axis_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// Single-axis raster counter: wraps at TOTAL and decodes the
// active and sync windows from its next-state count.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL   = 8,
  parameter int unsigned ACT_END = 4,
  parameter int unsigned SYN_BEG = 5,
  parameter int unsigned SYN_END = 7,
  parameter int unsigned CW      = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output logic          term_o,
  output logic          act_d_o,
  output logic          sync_d_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign term_o = (cnt_q == CW'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) cnt_d = term_o ? '0 : cnt_q + CW'(1);
  end

  // Windows look at the next count so registered outputs line up
  assign act_d_o  = (cnt_d < CW'(ACT_END));
  assign sync_d_o = (cnt_d >= CW'(SYN_BEG)) && (cnt_d < CW'(SYN_END));

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= CW'(TOTAL - 1);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, data enable, pixel
// coordinates and line/frame start strobes.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_1080P60.active,
  parameter int unsigned H_FP     = H_1080P60.fp,
  parameter int unsigned H_SYNC   = H_1080P60.sync,
  parameter int unsigned H_BP     = H_1080P60.bp,
  parameter int unsigned V_ACTIVE = V_1080P60.active,
  parameter int unsigned V_FP     = V_1080P60.fp,
  parameter int unsigned V_SYNC   = V_1080P60.sync,
  parameter int unsigned V_BP     = V_1080P60.bp,
  parameter bit          HS_POL   = POL_POS,
  parameter bit          VS_POL   = POL_POS,
  parameter int unsigned CW       = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic          hSyncPulse,
  output logic          vSyncPulse,
  output logic          dataEnable,
  output logic [CW-1:0] pixelX,
  output logic [CW-1:0] pixelY,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int unsigned H_TOTAL =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_bad_param
    $error("video_timing_gen: timing parameters must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CW) ||
      longint'(V_TOTAL) > (longint'(1) << CW))
  begin : g_bad_width
    $error("video_timing_gen: totals exceed counter width");
  end

  logic h_term, h_act_d, h_syn_d;
  logic v_term, v_act_d, v_syn_d;
  logic v_adv;

  logic hs_q, vs_q, de_q, ls_q, fs_q;

  assign v_adv = enable && h_term;

  timing_axis_counter #(
    .TOTAL  (H_TOTAL),
    .ACT_END(H_ACTIVE),
    .SYN_BEG(H_ACTIVE + H_FP),
    .SYN_END(H_ACTIVE + H_FP + H_SYNC),
    .CW     (CW)
  ) u_h (
    .clock   (clock),
    .reset   (reset),
    .adv_i   (enable),
    .cnt_o   (pixelX),
    .term_o  (h_term),
    .act_d_o (h_act_d),
    .sync_d_o(h_syn_d)
  );

  timing_axis_counter #(
    .TOTAL  (V_TOTAL),
    .ACT_END(V_ACTIVE),
    .SYN_BEG(V_ACTIVE + V_FP),
    .SYN_END(V_ACTIVE + V_FP + V_SYNC),
    .CW     (CW)
  ) u_v (
    .clock   (clock),
    .reset   (reset),
    .adv_i   (v_adv),
    .cnt_o   (pixelY),
    .term_o  (v_term),
    .act_d_o (v_act_d),
    .sync_d_o(v_syn_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= h_syn_d ? HS_POL : ~HS_POL;
      vs_q <= v_syn_d ? VS_POL : ~VS_POL;
      de_q <= h_act_d && v_act_d;
      // Strobes mark the edge that wraps into column 0 / origin
      ls_q <= enable && h_term;
      fs_q <= enable && h_term && v_term;
    end
  end

  assign hSyncPulse = hs_q;
  assign vSyncPulse = vs_q;
  assign dataEnable = de_q;
  assign lineStart  = ls_q;
  assign frameStart = fs_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator and successor to the single-pulse horizontal sync block.
- Produces horizontal and vertical sync with programmable porches and polarity, plus data-enable, pixel coordinates and line/frame start strobes for the HDMI overlay pipeline.
- Sits at the head of the video path. It drives the TMDS encoder control inputs, and the overlay mixer uses pixelX/pixelY to address overlay memory.

Parameters:
- H_ACTIVE, 1920, visible pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, horizontal sync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, visible lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hSyncPulse active level
- VS_POL, 1, vSyncPulse active level
- CW, 12, coordinate counter width

Ports:
- clock  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  pixel advance qualifier; counters step only when high
- hSyncPulse  output  1  horizontal sync, level per HS_POL
- vSyncPulse  output  1  vertical sync, level per VS_POL
- dataEnable  output  1  high inside the active region
- pixelX  output  CW  horizontal count, 0..H_TOTAL-1
- pixelY  output  CW  vertical count, 0..V_TOTAL-1
- lineStart  output  1  one-clock strobe when pixelX becomes 0
- frameStart  output  1  one-clock strobe when pixelX and pixelY both become 0

Behaviour:
- Interface: one clock named clock; reset named reset is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration checks: every timing parameter must be >= 1, and H_TOTAL and V_TOTAL must each be <= 2^CW. A violation is an elaboration error.
- Reset (has priority over enable):
  - pixelX = H_TOTAL-1, pixelY = V_TOTAL-1, i.e. the last back-porch pixel.
  - dataEnable = 0, hSyncPulse = !HS_POL, vSyncPulse = !VS_POL, lineStart = 0, frameStart = 0.
- Counter stepping on a clock edge with enable high:
  - pixelX increments; at H_TOTAL-1 it wraps to 0.
  - pixelY increments only on an pixelX wrap; at V_TOTAL-1 it wraps to 0.
- Output timing:
  - All outputs are registered and decoded from the next-state counter values, so every output is consistent with the pixelX/pixelY presented in the same cycle.
  - Latency from counter to outputs is zero; the first enabled edge after reset presents (0,0).
- Output decode:
  - dataEnable = (pixelX < H_ACTIVE) && (pixelY < V_ACTIVE).
  - hSyncPulse is active when H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC.
  - vSyncPulse is active when V_ACTIVE+V_FP <= pixelY < V_ACTIVE+V_FP+V_SYNC. It changes only together with pixelY, i.e. at the pixelX 0 boundary.
- Strobes:
  - lineStart is high for exactly one clock after an enabled edge that produced pixelX = 0.
  - frameStart is high for exactly one clock after an enabled edge that produced (0,0); lineStart is also high in that clock.
  - If enable is low on the following edge, both strobes clear while the counters hold.
- enable low: pixelX, pixelY, dataEnable and both syncs hold their values, and the strobes are 0.
- Reset mid-frame: the next cycle shows the reset values. Normal sequencing resumes from (H_TOTAL-1, V_TOTAL-1), so the first enabled edge after release produces frameStart.
- Arithmetic: comparisons are unsigned at CW bits. No counter ever exceeds its total minus 1.

Decomposition:
- Shared package video_timing_pkg holds:
  - standard-mode constants for 1080p60, 720p60 and 480p60;
  - a function computing totals from the porch parameters;
  - the polarity constants.
- Sub-module timing_axis_counter: a single-axis counter with advance input, wrap at a parameter total, terminal-count output, and sync-window/active-window compare.
  - Instantiated twice: horizontal (advance = enable) and vertical (advance = enable && horizontal terminal).

Test Plan:
- Reset, then release with enable=1, using H 4/1/2/1 (total 8) and V 3/1/1/1 (total 6):
  - first cycle shows pixelX=0, pixelY=0, dataEnable=1, lineStart=1, frameStart=1;
  - frameStart recurs every 48 clocks.
- Same config, line 0:
  - dataEnable is high for pixelX 0..3;
  - hSyncPulse equals HS_POL exactly at pixelX 5..6;
  - lineStart pulses every 8 clocks.
- Same config, full frame:
  - vSyncPulse is active for pixelY=4 only, spanning all 8 pixels of that line;
  - dataEnable is never high for pixelY >= 3.
- enable toggled 1,0,0,1 mid-line at pixelX=2:
  - pixelX holds at 2 for two cycles, then goes to 3;
  - the strobe raised at pixelX=0 lasts one clock regardless of enable.
- Reset asserted at pixelX=5, pixelY=2:
  - the next cycle shows pixelX=7, pixelY=5, syncs inactive, dataEnable=0;
  - after release, frameStart fires on the first enabled edge.
- HS_POL=0, VS_POL=0 with the same config:
  - sync levels are inverted against the windows above;
  - reset levels are 1.
